// File: rtl/posit_pkg.sv
// Shared helpers for the posit arithmetic blocks: width arithmetic and
// constant word builders.
package posit_pkg;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [63:0] nar_word(input int n);
    return 64'(1) << (n - 1);
  endfunction

  function automatic logic [63:0] zero_word(input int n);
    return 64'(0) & ((64'(1) << n) - 64'(1));
  endfunction

  function automatic logic [63:0] maxpos_word(input int n);
    return (64'(1) << (n - 1)) - 64'(1);
  endfunction

  // Mantissa (hidden bit + fraction) followed by guard, round and sticky.
  function automatic int ext_w(input int n);
    return n + 3;
  endfunction

  function automatic int scale_w(input int bs, input int es);
    return bs + es + 2;
  endfunction

endpackage

// File: rtl/posit_decode.sv
// Splits one posit into sign, special flags, signed scale (k*2^es + e) and a
// mantissa with the hidden one at the MSB.
module posit_decode
  import posit_pkg::*;
#(
  parameter int N  = 8,
  parameter int es = 2,
  parameter int SW = 7
) (
  input  logic [N-1:0]         p_i,
  output logic                 sign_o,
  output logic                 zero_o,
  output logic                 nar_o,
  output logic signed [SW-1:0] scale_o,
  output logic [N-1:0]         man_o
);

  localparam logic [N-1:0] NAR  = N'(nar_word(N));
  localparam logic [N-1:0] ZERO = N'(zero_word(N));

  logic [N-1:0] mag;
  logic [N-2:0] body;
  logic [N-2:0] rest;
  logic         rbit;
  logic         run_on;
  int           run;
  int           k;
  int           e;

  always_comb begin
    mag    = p_i[N-1] ? (~p_i + 1'b1) : p_i;
    body   = mag[N-2:0];
    rbit   = body[N-2];
    run    = 0;
    run_on = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (run_on && (body[i] == rbit)) run = run + 1;
      else run_on = 1'b0;
    end
    // Drop the regime run and its terminator; exponent then fraction remain.
    rest    = body << (run + 1);
    k       = rbit ? (run - 1) : -run;
    e       = int'(rest >> (N - 1 - es));
    scale_o = SW'(k * (2 ** es) + e);
    man_o   = {1'b1, rest << es};
    sign_o  = p_i[N-1];
    zero_o  = (p_i == ZERO);
    nar_o   = (p_i == NAR);
  end

endmodule

// File: rtl/posit_add.sv
// Single-cycle posit adder: decode, align, add, normalize, round and encode
// feed result registers loaded on start.
module posit_add
  import posit_pkg::*;
#(
  parameter int N  = 8,
  parameter int es = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         start,
  output logic [N-1:0] out,
  output logic         inf,
  output logic         zero,
  output logic         done
);

  localparam int Bs  = log2(N);
  localparam int SW  = scale_w(Bs, es);
  localparam int SWX = SW + 2;
  localparam int EW  = ext_w(N);
  localparam int TW  = es + EW;
  localparam int XW  = N + TW;
  localparam logic [N-1:0] NAR    = N'(nar_word(N));
  localparam logic [N-1:0] ZERO   = N'(zero_word(N));
  localparam logic [N-1:0] MAXPOS = N'(maxpos_word(N));
  localparam logic [N-1:0] MINPOS = N'(1);

  logic                 sa, sb, za, zb, na, nb;
  logic signed [SW-1:0] xa, xb;
  logic [N-1:0]         ma, mb;

  posit_decode #(.N(N), .es(es), .SW(SW)) u_dec_a (
    .p_i(in1), .sign_o(sa), .zero_o(za), .nar_o(na), .scale_o(xa), .man_o(ma)
  );

  posit_decode #(.N(N), .es(es), .SW(SW)) u_dec_b (
    .p_i(in2), .sign_o(sb), .zero_o(zb), .nar_o(nb), .scale_o(xb), .man_o(mb)
  );

  logic                  a_big, sg_big, sg_small;
  logic signed [SW-1:0]  sc_big, sc_small, diff;
  logic signed [SWX-1:0] sc_n;
  logic [N-1:0]          m_big, m_small;
  logic [EW-1:0]         ext_big, ext_small, shifted, frac_n;
  logic                  lost;
  logic [EW:0]           sum;
  int                    lzc, kr, ef;
  logic [TW-1:0]         tail;
  logic signed [XW-1:0]  xs;
  logic [XW-1:0]         xu, xv;
  logic [N-2:0]          body, body_r;
  logic                  guard, sticky, rnd;
  logic [N-1:0]          mag_r, res_sum, res_d;
  logic                  inf_d, zero_d;
  logic [N-1:0]          out_q;
  logic                  inf_q, zero_q, done_q;

  always_comb begin
    a_big    = (xa > xb) || ((xa == xb) && (ma >= mb));
    sg_big   = a_big ? sa : sb;
    sg_small = a_big ? sb : sa;
    sc_big   = a_big ? xa : xb;
    sc_small = a_big ? xb : xa;
    m_big    = a_big ? ma : mb;
    m_small  = a_big ? mb : ma;
    diff     = sc_big - sc_small;

    ext_big   = {m_big, 3'b000};
    ext_small = {m_small, 3'b000};
    if (diff >= EW) begin
      shifted = '0;
      lost    = |m_small;
    end else begin
      shifted = ext_small >> diff;
      lost    = |(ext_small & ~({EW{1'b1}} << diff));
    end
    shifted[0] = shifted[0] | lost;

    sum = (sg_big == sg_small) ? ({1'b0, ext_big} + {1'b0, shifted})
                               : ({1'b0, ext_big} - {1'b0, shifted});

    // Normalize so the leading one sits just above frac_n.
    lzc = EW + 1;
    for (int i = 0; i <= EW; i++) begin
      if (sum[i]) lzc = EW - i;
    end
    frac_n = EW'(sum << lzc);
    sc_n   = SWX'(sc_big) + SWX'(1) - SWX'(lzc);

    kr   = int'(sc_n >>> es);
    ef   = int'(sc_n) - kr * (2 ** es);
    tail = (TW'(ef) << EW) | TW'(frac_n);

    // Regime is produced by shifting a "10" / "01" seed in front of the tail.
    xs = {2'b10, tail, {(N-2){1'b0}}};
    xu = {2'b01, tail, {(N-2){1'b0}}};
    if (kr >= 0) xv = xs >>> kr;
    else         xv = xu >> (-kr - 1);

    body   = xv[XW-1 -: N-1];
    guard  = xv[XW-N];
    sticky = |xv[XW-N-1:0];
    rnd    = guard & (sticky | body[0]);
    body_r = body + {{(N-2){1'b0}}, rnd};

    if (kr >= N - 2)         mag_r = MAXPOS;
    else if (kr < -(N - 2))  mag_r = MINPOS;
    else                     mag_r = {1'b0, body_r};
    res_sum = sg_big ? (~mag_r + 1'b1) : mag_r;

    if (na || nb)            res_d = NAR;
    else if (za && zb)       res_d = ZERO;
    else if (za)             res_d = in2;
    else if (zb)             res_d = in1;
    else if (sum == '0)      res_d = ZERO;
    else                     res_d = res_sum;
    inf_d  = (res_d == NAR);
    zero_d = (res_d == ZERO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      inf_q  <= 1'b0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= start;
      if (start) begin
        out_q  <= res_d;
        inf_q  <= inf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out  = out_q;
  assign inf  = inf_q;
  assign zero = zero_q;
  assign done = done_q;

endmodule

// File: tb/tb_posit_add.sv
// Bench for posit_add (N=8, es=2): directed cases plus random operands checked
// against a value-domain posit model.
module tb_posit_add;

  logic       clk;
  logic       rst;
  logic [7:0] in1, in2;
  logic       start;
  logic [7:0] out;
  logic       inf, zero, done;

  int n_chk  = 0;
  int n_fail = 0;

  posit_add #(.N(8), .es(2)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .start(start),
    .out(out), .inf(inf), .zero(zero), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value of an n-bit posit (es=2) in units of 2^-32.
  function automatic longint pval(input int n, input int p);
    int m, i, run, k, e, fb, sh;
    bit r, neg;
    longint sig, v;
    m   = p & ((1 << n) - 1);
    neg = m[n-1];
    if (neg) m = ((1 << n) - m) & ((1 << n) - 1);
    i   = n - 2;
    r   = m[i];
    run = 0;
    while (i >= 0 && m[i] == r) begin
      run++;
      i--;
    end
    k = r ? run - 1 : -run;
    i--;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = e * 2 + ((i >= 0) ? int'(m[i]) : 0);
      i--;
    end
    fb  = (i >= 0) ? i + 1 : 0;
    sig = longint'((1 << fb) | (m & ((1 << fb) - 1)));
    sh  = 4 * k + e - fb + 32;
    v   = sig << sh;
    return neg ? -v : v;
  endfunction

  // Exact sum, then round to the nearest posit; the tie point between two
  // neighbours is the posit one bit longer that sits between them.
  function automatic logic [7:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    longint s, mag, mid;
    logic [7:0] r;
    bit neg;
    if (a == 8'h80 || b == 8'h80) return 8'h80;
    if (a == 8'h00) return b;
    if (b == 8'h00) return a;
    s = pval(8, a) + pval(8, b);
    if (s == 0) return 8'h00;
    neg = (s < 0);
    mag = neg ? -s : s;
    if (mag >= pval(8, 8'h7F))      r = 8'h7F;
    else if (mag <= pval(8, 8'h01)) r = 8'h01;
    else begin
      r = 8'h01;
      for (int p = 1; p < 127; p++) if (pval(8, p) <= mag) r = 8'(p);
      mid = pval(9, int'({r, 1'b1}));
      if (mag > mid || (mag == mid && r[0])) r = r + 8'd1;
    end
    return neg ? (~r + 8'd1) : r;
  endfunction

  task automatic apply(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [7:0] exp);
    chk({tag, ".out"}, out, exp);
    chk({tag, ".inf"}, 8'(inf), 8'(exp == 8'h80));
    chk({tag, ".zero"}, 8'(zero), 8'(exp == 8'h00));
    chk({tag, ".done"}, 8'(done), 8'd1);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 11))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'h7F;
      3: return 8'h01;
      4: return 8'h81;
      default: return 8'($urandom);
    endcase
  endfunction

  logic [7:0] dir_a [7] = '{8'h5A, 8'h40, 8'h80, 8'h40, 8'h40, 8'h7F, 8'h00};
  logic [7:0] dir_b [7] = '{8'h50, 8'hC0, 8'h40, 8'h40, 8'h01, 8'h7F, 8'hB3};
  logic [7:0] dir_e [7] = '{8'h5E, 8'h00, 8'h80, 8'h48, 8'h40, 8'h7F, 8'hB3};

  initial begin
    logic [7:0] a, b, exp, last;
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    #12;
    chk("reset.out", out, 8'h00);
    chk("reset.inf", 8'(inf), 8'd0);
    chk("reset.zero", 8'(zero), 8'd0);
    chk("reset.done", 8'(done), 8'd0);
    @(negedge clk);
    rst = 1'b0;

    apply(dir_a[0], dir_b[0]);
    check_result("dir0", dir_e[0]);
    idle();
    chk("dir0.done_drop", 8'(done), 8'd0);
    chk("dir0.hold", out, dir_e[0]);

    for (int i = 1; i < 7; i++) begin
      apply(dir_a[i], dir_b[i]);
      check_result($sformatf("dir%0d", i), dir_e[i]);
      idle();
    end

    // Asynchronous reset while a result is valid.
    apply(8'h5A, 8'h50);
    #2 rst = 1'b1;
    #1;
    chk("async.out", out, 8'h00);
    chk("async.inf", 8'(inf), 8'd0);
    chk("async.zero", 8'(zero), 8'd0);
    chk("async.done", 8'(done), 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Start held for three edges with changing operands.
    for (int i = 0; i < 3; i++) begin
      a = pick();
      b = pick();
      apply(a, b);
      check_result($sformatf("held%0d", i), ref_add(a, b));
    end
    idle();
    chk("held.done_drop", 8'(done), 8'd0);

    for (int i = 0; i < 400; i++) begin
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? (~a + 8'd1) : pick();
      exp = ref_add(a, b);
      apply(a, b);
      check_result($sformatf("rnd%0d(%h+%h)", i, a, b), exp);
      last = exp;
      if ($urandom_range(0, 3) == 0) begin
        idle();
        chk($sformatf("rnd%0d.idle_done", i), 8'(done), 8'd0);
        chk($sformatf("rnd%0d.idle_hold", i), out, last);
      end
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/posit_add.md
Name: posit_add

Overview:
- Single-cycle, registered posit adder for `N`-bit posits with `es` exponent bits (posit standard encoding, two's-complement negatives).
- Combinational decode/align/add/normalize/round datapath feeds output registers, which are captured on a `start` strobe.
- Used as the addition unit in the posit arithmetic library.
- Flags identify NaR (`inf`) and zero results.

Parameters:
- `N`, 8, posit word width; must be ≥ 4.
- `es`, 2, exponent field width; must satisfy 0 ≤ es ≤ N-3.
- `Bs`, derived localparam = ceil(log2(N)), width of regime-run/shift counters; not overridable.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in1`  in  N  posit operand A.
- `in2`  in  N  posit operand B.
- `start`  in  1  capture strobe; operands sampled on a rising edge where `start`=1.
- `out`  out  N  posit sum, registered.
- `inf`  out  1  1 when `out` is NaR (1 followed by N-1 zeros), registered.
- `zero`  out  1  1 when `out` is 0, registered.
- `done`  out  1  result-valid pulse, registered.

Behaviour:
- Reset (async, `rst`=1): `out`=0, `inf`=0, `zero`=0, `done`=0 immediately; held while `rst`=1.
- Latency is 1 cycle. On a rising edge with `start`=1:
  - `out`/`inf`/`zero` load the sum of the current `in1`/`in2`.
  - `done`=1 during the following cycle.
- Rising edge with `start`=0: `done`←0; `out`/`inf`/`zero` hold their previous values.
- `start` held high: a new result is captured every cycle and `done` stays 1. No busy state; no back-pressure.
- Reset mid-operation discards the pending result.
- Decode (per operand):
  - Negative operand: take two's complement first.
  - Regime = run of identical bits after the sign. k = run−1 for a run of 1s, −run for a run of 0s.
  - Then up to `es` exponent bits; missing bits are zero-filled.
  - Remaining bits are the fraction, with hidden 1.
  - Scale = k·2^es + e.
- Add:
  - Swap so operand A has the larger magnitude.
  - Right-shift B's mantissa by the scale difference, keeping guard, round and sticky bits.
  - Add if signs are equal, else subtract.
  - Result sign = sign of the larger-magnitude operand.
- Normalize: leading-zero count on the sum; adjust scale by +1 on carry-out, or by −lzc on cancellation.
- Encode:
  - Build the regime, `es` exponent bits and fraction into an extended bit string.
  - Round to nearest, ties to even, using guard and sticky.
  - Two's-complement the result if the sign is negative.
- Saturation:
  - Magnitude above maxpos (0111…1) → maxpos.
  - Nonzero magnitude below minpos (000…01) → minpos.
  - Never round to 0 or NaR.
- Special cases (priority order):
  1. Either operand NaR → `out`=NaR, `inf`=1, `zero`=0.
  2. Both operands zero → `out`=0, `zero`=1.
  3. Exactly one operand zero → `out`=the other operand, unchanged.
  4. Exact cancellation (x + −x) → `out`=0, `zero`=1, `inf`=0.
- `inf` and `zero` are never both 1.

Decomposition:
- Package `posit_pkg`: `log2` constant function, NaR/zero/maxpos constant builders, and widths of extended mantissa/scale fields (scale width Bs+es+2, signed).
- One natural sub-module, `posit_decode`, instantiated twice. Outputs: sign, zero flag, NaR flag, signed scale, mantissa with hidden bit.
- Align, add, normalize, encode and output registers stay in `posit_add`.

Test Plan (N=8, es=2):
- in1=0x5A (10.0), in2=0x50 (4.0), `start` pulsed for one edge → next cycle `out`=0x5E (14.0), inf=0, zero=0, done=1, then done=0.
- in1=0x40 (1.0), in2=0xC0 (−1.0) → `out`=0x00, zero=1, inf=0.
- in1=0x80 (NaR), in2=0x40 → `out`=0x80, inf=1, zero=0.
- in1=0x40, in2=0x40 → `out`=0x48 (2.0); in1=0x40, in2=0x01 (minpos) → `out`=0x40 (rounding/sticky).
- Saturation: in1=0x7F, in2=0x7F → `out`=0x7F. Zero passthrough: in1=0x00, in2=0xB3 → `out`=0xB3.
- Reset and strobe control:
  - `rst` asserted between edges while done=1 → out/inf/zero/done go 0 immediately, without a clock edge.
  - `start` held for 3 edges with changing inputs → done stays 1 and out updates every cycle.
